// File: rtl/dst_drain_pkg.sv
// Shared types and helpers for the dst_buf drain engine.
package dst_drain_pkg;

  localparam int unsigned DefAw = 13;

  typedef enum logic [1:0] {StIdle, StIssue, StFlush, StDone} state_e;

  // float32 -> bfloat16, round-to-nearest-even; every NaN collapses to the canonical quiet NaN.
  function automatic logic [15:0] f32_to_bf16(input logic [31:0] f);
    logic round_up;
    if (&f[30:23] && |f[22:0]) return 16'h7fc0;
    round_up = f[15] && (f[16] || |f[14:0]);
    return f[31:16] + {15'd0, round_up};
  endfunction

endpackage

// File: rtl/dst_drain_fifo.sv
// Synchronous output FIFO for dst_drain; resets to empty with zeroed storage.
module dst_drain_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dst_drain.sv
// Drains a dst_buf address range onto a valid/ready stream.
// Define DST_DRAIN_BF16_EN to narrow each float32 lane to bfloat16 at FIFO write.
module dst_drain
  import dst_drain_pkg::*;
#(
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          dst_v,
  output logic [AW-1:0] dst_a,
  input  logic [DW-1:0] dst_d0,
  input  logic [DW-1:0] dst_d1,
  output logic          m_valid,
  input  logic          m_ready,
`ifdef DST_DRAIN_BF16_EN
  output logic [31:0]   m_data,
`else
  output logic [2*DW-1:0] m_data,
`endif
  output logic          m_last
);

`ifdef DST_DRAIN_BF16_EN
  localparam int unsigned MW = 32;
`else
  localparam int unsigned MW = 2 * DW;
`endif
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, len_q, issued_q;
  logic          inflight_q, inflight_last_q;
  logic          last_issue, can_issue, drained, pop;

  logic [MW:0]   fifo_wdata, fifo_rdata;
  logic [MW-1:0] land_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

`ifdef DST_DRAIN_BF16_EN
  assign land_data = {f32_to_bf16(dst_d1), f32_to_bf16(dst_d0)};
`else
  assign land_data = {dst_d1, dst_d0};
`endif

  assign fifo_wdata = {inflight_last_q, land_data};
  assign pop        = !fifo_empty && m_ready;
  assign last_issue = (issued_q == len_q - AW'(1));
  // Reserve a FIFO slot for every read still in flight; no m_ready in this path.
  assign can_issue  = !fifo_full && ((32'(fifo_count) + 32'(inflight_q)) < DEPTH);
  // FIFO will be empty after this edge, so done lands right after the last beat.
  assign drained    = !inflight_q && (fifo_empty || (fifo_count == CW'(1) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (len == '0) ? StDone : StIssue;
      StIssue: if (dst_v && last_issue) state_d = StFlush;
      StFlush: if (drained) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q == StIssue) || (state_q == StFlush);
    done  = (state_q == StDone);
    dst_v = (state_q == StIssue) && can_issue;
    dst_a = base_q + issued_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        base_q   <= base;
        len_q    <= len;
        issued_q <= '0;
      end else if (dst_v) begin
        issued_q <= issued_q + AW'(1);
      end
      inflight_q      <= dst_v;
      inflight_last_q <= dst_v && last_issue;
    end
  end

  dst_drain_fifo #(
    .Width (MW + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_rdata[MW-1:0];
  assign m_last  = fifo_rdata[MW];

endmodule

// File: tb/tb_dst_drain.sv
// Scoreboard bench for dst_drain: directed drains with a dst_buf model and decoupled monitor.
module tb_dst_drain;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef DST_DRAIN_BF16_EN
  localparam int MW = 32;
`else
  localparam int MW = 2 * DW;
`endif

  typedef logic [127:0] w_t;
  typedef struct {
    logic [MW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n, start, m_ready;
  logic [AW-1:0] base, len;
  logic          busy, done, dst_v, m_valid, m_last;
  logic [AW-1:0] dst_a;
  logic [DW-1:0] dst_d0 = '0, dst_d1 = '0;
  logic [MW-1:0] m_data;

  logic [31:0]   mem0 [2**AW];
  logic [31:0]   mem1 [2**AW];

  beat_t         sb[$];
  beat_t         e;
  logic [AW-1:0] alog[$];
  logic [MW:0]   held;
  logic [15:0]   rdy_tbl = 16'b1001_0110_0100_0000;

  int  vectors = 0, errors = 0;
  int  cyc = 0, c0 = 0;
  int  done_cyc, done_cnt, dv_cnt, beat_cnt, out, max_out;
  bit  done_seen, stall_q;

  dst_drain #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .dst_v   (dst_v),
    .dst_a   (dst_a),
    .dst_d0  (dst_d0),
    .dst_d1  (dst_d1),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dst_buf model: one-cycle read latency
  always @(posedge clk) begin
    if (dst_v) begin
      dst_d0 <= mem0[dst_a];
      dst_d1 <= mem1[dst_a];
    end
  end

  task automatic chk(input string name, input w_t act, input w_t exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] pk(input logic [31:0] d1, input logic [31:0] d0);
`ifdef DST_DRAIN_BF16_EN
    // bench data keeps bits [15:0] below the rounding point, so bf16 is the upper half
    return {d1[31:16], d0[31:16]};
`else
    return {d1, d0};
`endif
  endfunction

  task automatic put(input logic [AW-1:0] a, input logic [31:0] d0, input logic [31:0] d1);
    mem0[a] = d0;
    mem1[a] = d1;
  endtask

  task automatic expect_beat(input logic [MW-1:0] d, input logic l, input int c);
    sb.push_back('{data: d, last: l, cyc: c});
  endtask

  task automatic clear_trk();
    done_seen = 0;
    done_cnt  = 0;
    dv_cnt    = 0;
    beat_cnt  = 0;
    out       = 0;
    max_out   = 0;
    alog.delete();
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 0;
    end else begin
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc - c0;
        done_cnt++;
        chk("busy_and_done", w_t'(busy), w_t'(0));
      end
      if (dst_v) begin
        alog.push_back(dst_a);
        dv_cnt++;
        out++;
        if (out > max_out) max_out = out;
      end
      if (stall_q) chk("stall_hold", w_t'({m_valid, m_last, m_data}), w_t'({1'b1, held}));
      if (m_valid && m_ready) begin
        beat_cnt++;
        out--;
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_beat: got %0h last %0b, expected no beat", m_data, m_last);
        end else begin
          e = sb.pop_front();
          chk("beat_data", w_t'(m_data), w_t'(e.data));
          chk("beat_last", w_t'(m_last), w_t'(e.last));
          if (e.cyc >= 0) chk("beat_cycle", w_t'(cyc - c0), w_t'(e.cyc));
        end
      end
      stall_q = m_valid && !m_ready;
      held    = {m_last, m_data};
    end
  end

  task automatic drain(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit bp,
                       input int budget);
    clear_trk();
    @(posedge clk);
    #1;
    start   = 1'b1;
    base    = b;
    len     = l;
    c0      = cyc;
    m_ready = bp ? rdy_tbl[0] : 1'b1;
    for (int k = 1; k < budget && !done_seen; k++) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      m_ready = bp ? rdy_tbl[4'(k)] : 1'b1;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk("done_seen", w_t'(done_seen), w_t'(1));
    chk("sb_drained", w_t'(sb.size()), w_t'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", w_t'(done_cnt), w_t'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    w_t'(busy),    w_t'(0));
    chk({tag, "_done"},    w_t'(done),    w_t'(0));
    chk({tag, "_dst_v"},   w_t'(dst_v),   w_t'(0));
    chk({tag, "_dst_a"},   w_t'(dst_a),   w_t'(0));
    chk({tag, "_m_valid"}, w_t'(m_valid), w_t'(0));
    chk({tag, "_m_data"},  w_t'(m_data),  w_t'(0));
    chk({tag, "_m_last"},  w_t'(m_last),  w_t'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] wexp [4];
    wexp = '{13'h1ffe, 13'h1fff, 13'h0000, 13'h0001};
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;

    for (int i = 0; i < 4; i++) put(AW'(i), 32'(i), 32'(32'h100 + i));
    for (int i = 0; i < 8; i++)
      put(AW'(32'h10 + i), {16'(32'h10 + i), 16'h0011}, {16'(32'h30 + i), 16'h0022});
    for (int i = 0; i < 8; i++) put(AW'(32'h40 + i), 32'(32'h7000 + i), 32'(32'h7100 + i));
    put(13'h1ffe, 32'h55, 32'h155);
    put(13'h1fff, 32'h56, 32'h156);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Normal drain
    for (int i = 0; i < 4; i++) expect_beat(pk(32'(32'h100 + i), 32'(i)), i == 3, 3 + i);
    drain(13'h0, 13'd4, 1'b0, 50);
    chk("normal_done_cycle", w_t'(done_cyc), w_t'(7));
    chk("normal_reads", w_t'(dv_cnt), w_t'(4));
    chk("normal_beats", w_t'(beat_cnt), w_t'(4));

    // Backpressure
    for (int i = 0; i < 8; i++)
      expect_beat(pk({16'(32'h30 + i), 16'h0022}, {16'(32'h10 + i), 16'h0011}), i == 7, -1);
    drain(13'h10, 13'd8, 1'b1, 300);
    chk("bp_beats", w_t'(beat_cnt), w_t'(8));
    chk("bp_reads", w_t'(dv_cnt), w_t'(8));
    chk("bp_max_outstanding", w_t'(max_out), w_t'(DEPTH));

    // Empty drain
    drain(13'h0, 13'd0, 1'b0, 20);
    chk("empty_done_cycle", w_t'(done_cyc), w_t'(1));
    chk("empty_reads", w_t'(dv_cnt), w_t'(0));
    chk("empty_beats", w_t'(beat_cnt), w_t'(0));

    // Address wrap
    expect_beat(pk(32'h155, 32'h55), 1'b0, 3);
    expect_beat(pk(32'h156, 32'h56), 1'b0, 4);
    expect_beat(pk(32'h100, 32'h0), 1'b0, 5);
    expect_beat(pk(32'h101, 32'h1), 1'b1, 6);
    drain(13'h1ffe, 13'd4, 1'b0, 50);
    chk("wrap_reads", w_t'(alog.size()), w_t'(4));
    for (int k = 0; k < 4; k++)
      chk("wrap_addr", w_t'((k < alog.size()) ? alog[k] : 13'h0aaa), w_t'(wexp[k]));

    // Abort mid-drain, then restart
    for (int i = 0; i < 8; i++) expect_beat(pk(32'(32'h7100 + i), 32'(32'h7000 + i)), i == 7, 3 + i);
    clear_trk();
    @(posedge clk);
    #1;
    start = 1'b1; base = 13'h40; len = 13'd8; c0 = cyc; m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    chk("abort_beats_before", w_t'(beat_cnt), w_t'(1));
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", w_t'(done_cnt), w_t'(0));
    for (int i = 0; i < 4; i++) expect_beat(pk(32'(32'h100 + i), 32'(i)), i == 3, 3 + i);
    drain(13'h0, 13'd4, 1'b0, 50);
    chk("restart_done_cycle", w_t'(done_cyc), w_t'(7));
    chk("restart_beats", w_t'(beat_cnt), w_t'(4));

`ifdef DST_DRAIN_BF16_EN
    put(13'h80, 32'h3f800000, 32'h40000000);
    put(13'h81, 32'h3f808000, 32'h40000000);
    put(13'h82, 32'h3f818000, 32'h40000000);
    put(13'h83, 32'h7fa00001, 32'h40000000);
    expect_beat(32'h4000_3f80, 1'b0, 3);
    expect_beat(32'h4000_3f80, 1'b0, 4);
    expect_beat(32'h4000_3f82, 1'b0, 5);
    expect_beat(32'h4000_7fc0, 1'b1, 6);
    drain(13'h80, 13'd4, 1'b0, 50);
    chk("bf16_beats", w_t'(beat_cnt), w_t'(4));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dst_drain.md
# dst_drain

Read-side drain engine for `dst_buf`. It walks a programmable address range through the `dst_v`/`dst_a` read port and collects the `dst_d0`/`dst_d1` float32 pairs returned one cycle later. It delivers those pairs on a valid/ready stream toward the host/DMA side, absorbing backpressure in a small internal FIFO. It is the consumer of the results the accumulate path (`signo`/`expo`/`addo`, `accr`/`outr`) writes into `dst_buf`.

## Interface
- `AW`, 13: `dst_buf` address width
- `DW`, 32: width of each `dst_d*` word
- `DEPTH`, 4: output FIFO entries, power of 2, ≥ 2
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle request to begin a drain
- `base` in AW: first address to read
- `len` in AW: number of address reads (pairs), 0 allowed
- `busy` out 1: drain in progress
- `done` out 1: one-cycle completion pulse
- `dst_v` out 1: read strobe to `dst_buf`
- `dst_a` out AW: read address
- `dst_d0` in DW: read data lane 0, valid the cycle after `dst_v`
- `dst_d1` in DW: read data lane 1, valid the cycle after `dst_v`
- `m_valid` out 1: stream data valid
- `m_ready` in 1: stream sink ready
- `m_data` out 2*DW (or 32, see Configuration): `{dst_d1, dst_d0}`
- `m_last` out 1: marks the final beat of a drain

## Operation
- FSM states:
  - IDLE: on `start`, latch `base` and `len`. Go to ISSUE, or to DONE if `len` is 0.
  - ISSUE: issue reads. After `len` reads have issued, go to FLUSH.
  - FLUSH: wait until all in-flight reads have landed and the FIFO is empty, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Read issue: a read issues in ISSUE whenever FIFO count plus in-flight count is less than DEPTH. Only registered values are used, so there is no combinational path from `m_ready` to `dst_v`.
- Addresses: `dst_a` = `base + i` modulo 2^AW, for i = 0..len-1. The address wraps silently.
- One read is in flight per cycle. Returned data is written into the FIFO the cycle after `dst_v`.
- `m_last` is set on the beat carrying read index len-1.
- A beat transfers when `m_valid && m_ready`. `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
- `start` while `busy` is ignored.
- `busy` is high in ISSUE and FLUSH. `busy` and `done` are mutually exclusive.
- Simultaneous FIFO push and pop when full or empty are both legal; the count stays consistent.
- Asserting `rst_n` mid-drain aborts the drain, discards the FIFO contents and in-flight reads, and does not pulse `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `dst_v`=0, `dst_a`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
- Reset is asynchronous assert, synchronous release.
- `start` is sampled at cycle 0. `busy` and the first `dst_v` go high at cycle 1. Data lands in the FIFO at cycle 2. The first `m_valid` is at cycle 3.
- With `m_ready` held at 1, throughput is one beat per cycle with no bubbles. The last beat comes at cycle len+2 and `done` at cycle len+3.
- With `len`=0, `done` pulses at cycle 1 and `dst_v` never asserts.
- When `m_ready` drops, issue stalls within DEPTH beats. No beat is lost or duplicated.

## Configuration
- `DST_DRAIN_BF16_EN` defined:
  - Each float32 word is converted to bfloat16 with round-to-nearest-even on bits [15:0].
  - Any NaN input becomes 16'h7fc0. Overflow to infinity is allowed.
  - `m_data` is 32 bits, `{bf16(d1), bf16(d0)}`.
  - Conversion happens at FIFO write, so the latency is unchanged.
- Not defined: no conversion; `m_data` is 2*DW raw.

## Structure
- `dst_drain_pkg` holds:
  - the FSM state enum
  - the default `AW`
  - the `f32_to_bf16` rounding function
- Sub-module `dst_drain_fifo`: a synchronous FIFO of DEPTH entries, width `m_data` + 1 (the extra bit is `last`). It provides `count`, `full` and `empty`, and resets to empty.
- The top level holds the FSM, the address and issue counters, and the in-flight tracking.

## Test plan
- Normal drain: preload addresses 0..3 with (d0,d1) = (i, 0x100+i); `start`, `base`=0, `len`=4, `m_ready`=1. Expect:
  - 4 beats `{0x100+i, i}` on cycles 3..6
  - `m_last` only on cycle 6
  - `done` on cycle 7
- Backpressure: `len`=8 with `m_ready` toggling 1,0,0,1 pseudo-randomly. Expect:
  - all 8 beats in order, with no duplicates
  - `m_data` stable across every stalled cycle
  - `dst_v` stalls once DEPTH beats are outstanding
- Empty drain: `len`=0. Expect `done` at cycle 1, no `dst_v`, no `m_valid`.
- Address wrap: `base`=13'h1ffe, `len`=4. Expect `dst_a` sequence 1ffe, 1fff, 0000, 0001.
- Abort and restart: `rst_n` low during beat 2 of an 8-beat drain. Expect all outputs at reset values. A new drain started afterwards completes cleanly with no stale beats.
- BF16 conversion (`DST_DRAIN_BF16_EN`):
  - d0 = 32'h3f800000 → 16'h3f80
  - d0 = 32'h3f808000 → 16'h3f80 (tie, rounds to even)
  - d0 = 32'h3f818000 → 16'h3f82
  - d0 = 32'h7fa00001 → 16'h7fc0
